// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared command codes, state/phase enums and init-command lookup
package lcd_pkg;

  localparam logic [7:0] LCD_CMD_FUNC  = 8'h38;
  localparam logic [7:0] LCD_CMD_DISP  = 8'h0C;
  localparam logic [7:0] LCD_CMD_ENTRY = 8'h06;
  localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
  localparam logic [7:0] LCD_CMD_LINE1 = 8'h80;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_INIT,
    ST_SET_ADDR,
    ST_WR_CHAR,
    ST_DONE
  } lcd_state_t;

  typedef enum logic [1:0] {
    PH_P0,
    PH_P1,
    PH_P2
  } lcd_phase_t;

  // Init sequence order: function set, display on, entry mode, clear
  function automatic logic [7:0] lcd_init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return LCD_CMD_FUNC;
      2'd1:    return LCD_CMD_DISP;
      2'd2:    return LCD_CMD_ENTRY;
      default: return LCD_CMD_CLEAR;
    endcase
  endfunction

endpackage

// File: rtl/lcd_write_module_if.sv
// rtl/lcd_write_module_if.sv - ROM fetch and LCD pin bundle between ROM stage, controller and panel
interface lcd_write_module_if;
  logic [7:0] rom_data_after;
  logic [4:0] rom_addr_after;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;
  logic [7:0] lcd_data;
  logic       frame_done;

  modport master (
    input  rom_data_after,
    output rom_addr_after, lcd_rs, lcd_rw, lcd_en, lcd_data, frame_done
  );

  modport slave (
    output rom_data_after,
    input  rom_addr_after, lcd_rs, lcd_rw, lcd_en, lcd_data, frame_done
  );
endinterface

// File: rtl/lcd_tick_gen.sv
// rtl/lcd_tick_gen.sv - free-running phase tick, one pulse every STEP_CYCLES clocks
module lcd_tick_gen #(
  parameter int STEP_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == CW'(STEP_CYCLES - 1));
  assign tick   = w_wrap;

  // Count 0..STEP_CYCLES-1 and wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/lcd_write_module.sv
// rtl/lcd_write_module.sv - HD44780 init + line-1 writer; LCD_REFRESH_EN selects continuous rewrite
module lcd_write_module
  import lcd_pkg::*;
#(
  parameter int STEP_CYCLES   = 50000,
  parameter int POWERUP_TICKS = 20,
  parameter int NUM_CHARS     = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  lcd_write_module_if.master bus
);

  localparam int PWR_W = $clog2(POWERUP_TICKS + 1) > 0 ? $clog2(POWERUP_TICKS + 1) : 1;

  logic             w_tick;
  logic             w_last_char;

  lcd_state_t       r_state, w_state;
  lcd_phase_t       r_phase, w_phase;
  logic [1:0]       r_cmd,   w_cmd;
  logic [PWR_W-1:0] r_pwr,   w_pwr;
  logic [4:0]       r_addr,  w_addr;
  logic             r_rs,    w_rs;
  logic             r_en,    w_en;
  logic [7:0]       r_data,  w_data;
  logic             r_done,  w_done;

  lcd_tick_gen #(.STEP_CYCLES(STEP_CYCLES)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (w_tick)
  );

  assign w_last_char = (r_addr == 5'(NUM_CHARS - 1));

  assign bus.rom_addr_after = r_addr;
  assign bus.lcd_rs         = r_rs;
  assign bus.lcd_rw         = 1'b0;
  assign bus.lcd_en         = r_en;
  assign bus.lcd_data       = r_data;
  assign bus.frame_done     = r_done;

  // Registered FSM and pin state; reset clears pins without waiting for a clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_PWRUP;
      r_phase <= PH_P0;
      r_cmd   <= '0;
      r_pwr   <= '0;
      r_addr  <= '0;
      r_rs    <= 1'b0;
      r_en    <= 1'b0;
      r_data  <= 8'h00;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_phase <= w_phase;
      r_cmd   <= w_cmd;
      r_pwr   <= w_pwr;
      r_addr  <= w_addr;
      r_rs    <= w_rs;
      r_en    <= w_en;
      r_data  <= w_data;
      r_done  <= w_done;
    end
  end

  // Next state: everything advances on tick; bus is loaded when a transfer enters P0,
  // address steps when a char enters P2 so ROM data has a full phase to settle
  always_comb begin
    w_state = r_state;
    w_phase = r_phase;
    w_cmd   = r_cmd;
    w_pwr   = r_pwr;
    w_addr  = r_addr;
    w_rs    = r_rs;
    w_en    = r_en;
    w_data  = r_data;
    w_done  = 1'b0;
    if (w_tick) begin
      case (r_state)
        ST_PWRUP: begin
          if (int'(r_pwr) + 1 >= POWERUP_TICKS) begin
            w_state = ST_INIT;
            w_phase = PH_P0;
            w_cmd   = 2'd0;
            w_rs    = 1'b0;
            w_data  = lcd_init_cmd(2'd0);
          end else begin
            w_pwr = r_pwr + 1'b1;
          end
        end
        ST_DONE: begin
          w_en = 1'b0;
        end
        default: begin
          case (r_phase)
            PH_P0: begin
              w_phase = PH_P1;
              w_en    = 1'b1;
            end
            PH_P1: begin
              w_phase = PH_P2;
              w_en    = 1'b0;
              if (r_state == ST_WR_CHAR) begin
                if (w_last_char) begin
                  w_addr = '0;
                  w_done = 1'b1;
                end else begin
                  w_addr = r_addr + 1'b1;
                end
              end
            end
            default: begin
              w_phase = PH_P0;
              case (r_state)
                ST_INIT: begin
                  if (r_cmd == 2'd3) begin
                    w_state = ST_SET_ADDR;
                    w_rs    = 1'b0;
                    w_data  = LCD_CMD_LINE1;
                  end else begin
                    w_cmd  = r_cmd + 2'd1;
                    w_data = lcd_init_cmd(r_cmd + 2'd1);
                  end
                end
                ST_SET_ADDR: begin
                  w_state = ST_WR_CHAR;
                  w_rs    = 1'b1;
                  w_data  = bus.rom_data_after;
                end
                default: begin
                  // Address already wrapped to 0 means the last char just finished
                  if (r_addr == 5'd0) begin
`ifdef LCD_REFRESH_EN
                    w_state = ST_SET_ADDR;
                    w_rs    = 1'b0;
                    w_data  = LCD_CMD_LINE1;
`else
                    w_state = ST_DONE;
`endif
                  end else begin
                    w_rs   = 1'b1;
                    w_data = bus.rom_data_after;
                  end
                end
              endcase
            end
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_write_module.sv
// tb/tb_lcd_write_module.sv - directed bench: init order, char stream, ROM latency, async reset, refresh/done
module tb_lcd_write_module;

  logic clk;
  logic rst_n;
  bit   lat2;

  lcd_write_module_if bus_if();

  lcd_write_module #(
    .STEP_CYCLES   (4),
    .POWERUP_TICKS (2),
    .NUM_CHARS     (20)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: 0x41+addr, optionally delayed two cycles
  logic [7:0] rom_d1, rom_d2;
  always @(posedge clk) begin
    rom_d1 <= 8'h41 + {3'b000, bus_if.rom_addr_after};
    rom_d2 <= rom_d1;
  end
  assign bus_if.rom_data_after = lat2 ? rom_d2 : (8'h41 + {3'b000, bus_if.rom_addr_after});

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  typedef struct {
    logic       rs;
    logic [7:0] data;
    logic [4:0] addr;
    int         cyc;
  } strobe_t;

  strobe_t q[$];
  int      fd_t[$];
  int      cyc     = 0;
  int      rw_bad  = 0;
  int      fd_wide = 0;
  int      en_w    = 0;
  bit      en_prev = 1'b0;
  bit      fd_prev = 1'b0;

  // Bus monitor on the falling edge: strobe capture, enable width, frame_done pulses
  always @(negedge clk) begin
    strobe_t s;
    cyc++;
    if (bus_if.lcd_rw !== 1'b0) rw_bad++;
    if (!rst_n) begin
      en_prev = 1'b0;
      en_w    = 0;
      fd_prev = 1'b0;
    end else begin
      if (bus_if.lcd_en && !en_prev) begin
        s.rs   = bus_if.lcd_rs;
        s.data = bus_if.lcd_data;
        s.addr = bus_if.rom_addr_after;
        s.cyc  = cyc;
        q.push_back(s);
      end
      if (bus_if.lcd_en) begin
        en_w++;
      end else if (en_prev) begin
        check("en_width", en_w, 4);
        en_w = 0;
      end
      en_prev = bus_if.lcd_en;
      if (bus_if.frame_done) begin
        fd_t.push_back(cyc);
        if (fd_prev) fd_wide++;
      end
      fd_prev = bus_if.frame_done;
    end
  end

  task automatic wait_fd(input int n, input int budget);
    int k = 0;
    while (fd_t.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    check("fd_timeout", (fd_t.size() >= n), 1);
  endtask

  task automatic wait_strobes(input int n, input int budget);
    int k = 0;
    while (q.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    check("strobe_timeout", (q.size() >= n), 1);
  endtask

  task automatic check_reset_pins(input string tag);
    check({tag, "_addr"}, bus_if.rom_addr_after, 0);
    check({tag, "_rs"},   bus_if.lcd_rs, 0);
    check({tag, "_rw"},   bus_if.lcd_rw, 0);
    check({tag, "_en"},   bus_if.lcd_en, 0);
    check({tag, "_data"}, bus_if.lcd_data, 8'h00);
    check({tag, "_fd"},   bus_if.frame_done, 0);
  endtask

  task automatic check_pass(input string tag);
    logic [7:0] cmd_exp [5];
    cmd_exp = '{8'h38, 8'h0C, 8'h06, 8'h01, 8'h80};
    check({tag, "_count"}, q.size(), 25);
    if (q.size() >= 25) begin
      for (int i = 0; i < 5; i++) begin
        check($sformatf("%s_cmd%0d_rs", tag, i),   q[i].rs, 0);
        check($sformatf("%s_cmd%0d_data", tag, i), q[i].data, cmd_exp[i]);
      end
      for (int i = 0; i < 20; i++) begin
        check($sformatf("%s_chr%0d_rs", tag, i),   q[5+i].rs, 1);
        check($sformatf("%s_chr%0d_data", tag, i), q[5+i].data, 8'h41 + i);
        check($sformatf("%s_chr%0d_addr", tag, i), q[5+i].addr, i);
      end
    end
  endtask

  task automatic restart();
    @(posedge clk);
    #1 rst_n = 1'b0;
    q.delete();
    fd_t.delete();
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    lat2  = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset_pins("rst");
    @(negedge clk) rst_n = 1'b1;

    // Power-up wait: nothing on the bus for 8 cycles
    repeat (8) @(posedge clk);
    #1;
    check("pwrup_quiet", q.size(), 0);

    // First pass, zero-latency ROM
    wait_fd(1, 2000);
    #1;
    check_pass("p1");
    check("addr_wrap", bus_if.rom_addr_after, 0);
    check("fd_one_cycle", bus_if.frame_done, 0);
    if (q.size() >= 1 && fd_t.size() >= 1)
      check("pass_len", fd_t[0] - q[0].cyc, 292);

`ifdef LCD_REFRESH_EN
    wait_fd(2, 1000);
    if (fd_t.size() >= 2) check("refresh_spacing", fd_t[1] - fd_t[0], 252);
    check("refresh_cmd_present", (q.size() >= 27), 1);
    if (q.size() >= 27) begin
      check("refresh_line1_rs", q[25].rs, 0);
      check("refresh_line1_data", q[25].data, 8'h80);
      check("refresh_chr0_data", q[26].data, 8'h41);
    end
`else
    repeat (1000) @(posedge clk);
    check("done_no_strobes", q.size(), 25);
    check("done_fd_once", fd_t.size(), 1);
    #1;
    check("done_addr", bus_if.rom_addr_after, 0);
    check("done_en", bus_if.lcd_en, 0);
`endif

    // Two-cycle ROM latency
    lat2 = 1'b1;
    restart();
    wait_fd(1, 2000);
    #1;
    check_pass("lat2");

    // Asynchronous reset during P1 of char 7
    lat2 = 1'b0;
    restart();
    wait_strobes(13, 2000);
    #1;
    check("mid_en_high", bus_if.lcd_en, 1);
    if (q.size() >= 13) begin
      check("mid_chr7_data", q[12].data, 8'h48);
      check("mid_chr7_addr", q[12].addr, 7);
    end
    rst_n = 1'b0;
    #1;
    check("async_en_drop", bus_if.lcd_en, 0);
    check_reset_pins("async");
    q.delete();
    fd_t.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("restart_quiet", q.size(), 0);
    wait_strobes(1, 200);
    if (q.size() >= 1) begin
      check("restart_rs", q[0].rs, 0);
      check("restart_data", q[0].data, 8'h38);
    end

    check("rw_low", rw_bad, 0);
    check("fd_width", fd_wide, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
